// File: rtl/if_id_fifo_if.sv
// Fetch-to-decode instruction buffer bundle: fetch push side, decode pop side, EX flush.
// Pure wiring; the buffer itself adds one cycle between push and head visibility.
// Both sides use valid/ready; the slave (buffer) drives inst_ready_o and the head outputs.
interface if_id_fifo_if #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  // fetch side
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_valid_i;
  logic              inst_ready_o;
  // EX redirect
  logic              jump_flag_ex_i;
  // decode side
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_valid_o;
  logic              id_ready_i;
  logic [CNT_W-1:0]  count_o;

  // environment view: drives fetch data, flush and decode ready
  modport master (
    output inst_i, inst_addr_i, inst_valid_i, jump_flag_ex_i, id_ready_i,
    input  inst_ready_o, inst_o, inst_addr_o, inst_valid_o, count_o
  );

  // buffer view
  modport slave (
    input  inst_i, inst_addr_i, inst_valid_i, jump_flag_ex_i, id_ready_i,
    output inst_ready_o, inst_o, inst_addr_o, inst_valid_o, count_o
  );
endinterface

// File: rtl/if_id_fifo.sv
// IF/ID instruction buffer: DEPTH-entry circular FIFO of instruction/address pairs, flushed by EX jumps.
// Latency: a pair pushed at edge N is at the head in the cycle after edge N; outputs are registered-only.
// Backpressure: inst_ready_o drops when full (a same-cycle pop does not free the slot); decode stalls via id_ready_i.
module if_id_fifo #(
  parameter int              INST_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000001,
  parameter int              CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  if_id_fifo_if.slave       bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  logic not_empty;
  logic ready;
  logic push;
  logic pop;

  // Handshake qualifiers; a flush cycle swallows both push and pop.
  always_comb begin
    not_empty = (count != '0);
    ready     = (count < CNT_W'(DEPTH));
    push      = bus.inst_valid_i & ready & ~bus.jump_flag_ex_i;
    pop       = not_empty & bus.id_ready_i & ~bus.jump_flag_ex_i;
  end

  // Pointer and occupancy update: reset over flush over push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.jump_flag_ex_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are left stale on reset/flush since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr] <= bus.inst_i;
      addr_mem[wptr] <= bus.inst_addr_i;
    end
  end

  // Head presentation: NOP at address zero whenever the buffer is empty.
  always_comb begin
    bus.inst_ready_o = ready;
    bus.inst_valid_o = not_empty;
    bus.count_o      = count;
    bus.inst_o       = NOP_INST;
    bus.inst_addr_o  = '0;
    if (not_empty) begin
      bus.inst_o      = inst_mem[rptr];
      bus.inst_addr_o = addr_mem[rptr];
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo: DEPTH=2 instance for reset/stream/stall/flush, DEPTH=4 for wrap.
// Inputs driven 1 time unit after the rising edge; outputs checked at that point (registered-only).
// A bounded loop with a queue scoreboard checks ordering under a fixed decode stall pattern.
module tb_if_id_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_id_fifo_if #(.DEPTH(2)) b2 ();
  if_id_fifo_if #(.DEPTH(4)) b4 ();

  if_id_fifo #(.DEPTH(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
  if_id_fifo #(.DEPTH(4)) d4 (.clk(clk), .rst(rst), .bus(b4));

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic vld, input logic [31:0] addr, input logic rdy, input logic jmp);
    b2.inst_valid_i   = vld;
    b2.inst_addr_i    = addr;
    b2.inst_i         = 32'hA000_0000 | addr;
    b2.id_ready_i     = rdy;
    b2.jump_flag_ex_i = jmp;
  endtask

  // head/occupancy check on the DEPTH=2 instance
  task automatic head2(input string tag, input logic [31:0] addr, input int cnt);
    check({tag, "_cnt"}, b2.count_o, cnt);
    check({tag, "_addr"}, b2.inst_addr_o, addr);
    check({tag, "_inst"}, b2.inst_o, (cnt == 0) ? 32'h00000001 : (32'hA000_0000 | addr));
    check({tag, "_vld"}, b2.inst_valid_o, (cnt != 0));
    check({tag, "_rdy"}, b2.inst_ready_o, (cnt < 2));
  endtask

  initial begin
    logic [31:0] q[$];
    logic [15:0] pat;
    logic [31:0] waddr;
    logic        do_push;
    logic        do_pop;
    int          pushed;
    int          cyc;

    b4.inst_valid_i = 1'b0; b4.inst_i = '0; b4.inst_addr_i = '0;
    b4.id_ready_i = 1'b0; b4.jump_flag_ex_i = 1'b0;

    // reset held two cycles while fetch pushes garbage
    rst = 1'b0;
    drive2(1'b1, 32'h0, 1'b0, 1'b0);
    b2.inst_i = 32'hdeadbeef;
    tick(); tick();
    rst = 1'b1;
    drive2(1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_cnt", b2.count_o, 0);
    check("rst_vld", b2.inst_valid_o, 0);
    check("rst_inst", b2.inst_o, 32'h00000001);
    check("rst_addr", b2.inst_addr_o, 0);
    check("rst_rdy", b2.inst_ready_o, 1);
    check("rst4_cnt", b4.count_o, 0);
    tick();
    head2("idle", 32'h0, 0);

    // streaming with decode always ready; push+pop at count=1 keeps count at 1
    drive2(1'b1, 32'h0, 1'b1, 1'b0); tick(); head2("s0", 32'h0, 1);
    drive2(1'b1, 32'h4, 1'b1, 1'b0); tick(); head2("s1", 32'h4, 1);
    drive2(1'b1, 32'h8, 1'b1, 1'b0); tick(); head2("s2", 32'h8, 1);
    drive2(1'b0, 32'h0, 1'b1, 1'b0); tick(); head2("s3", 32'h0, 0);

    // fill and stall: third push refused while full
    drive2(1'b1, 32'h10, 1'b0, 1'b0); tick(); head2("f0", 32'h10, 1);
    drive2(1'b1, 32'h14, 1'b0, 1'b0); tick(); head2("f1", 32'h10, 2);
    drive2(1'b1, 32'h18, 1'b0, 1'b0); tick(); head2("f2", 32'h10, 2);
    // pop while full: no same-cycle push, ready returns next cycle
    drive2(1'b1, 32'h18, 1'b1, 1'b0); tick(); head2("f3", 32'h14, 1);
    drive2(1'b1, 32'h18, 1'b1, 1'b0); tick(); head2("f4", 32'h18, 1);
    drive2(1'b0, 32'h0, 1'b1, 1'b0);  tick(); head2("f5", 32'h0, 0);

    // flush while full, with a push and a pop presented in the same cycle
    drive2(1'b1, 32'h30, 1'b0, 1'b0); tick();
    drive2(1'b1, 32'h34, 1'b0, 1'b0); tick(); head2("j0", 32'h30, 2);
    drive2(1'b1, 32'h20, 1'b1, 1'b1); tick(); head2("j1", 32'h0, 0);
    drive2(1'b0, 32'h0, 1'b1, 1'b0);  tick(); head2("j2", 32'h0, 0);
    drive2(1'b1, 32'h40, 1'b0, 1'b0); tick(); head2("j3", 32'h40, 1);

    // reset mid-stream overrides a full buffer
    drive2(1'b1, 32'h44, 1'b0, 1'b0); tick(); head2("r0", 32'h40, 2);
    rst = 1'b0;
    drive2(1'b1, 32'h48, 1'b1, 1'b0); tick();
    rst = 1'b1;
    drive2(1'b0, 32'h0, 1'b0, 1'b0);
    head2("r1", 32'h0, 0);

    // wrap on DEPTH=4: 10 pushes under a fixed stall pattern, queue scoreboard
    pat    = 16'b1101_1011_0110_0000;
    pushed = 0;
    cyc    = 0;
    while ((pushed < 10 || q.size() != 0) && cyc < 200) begin
      check("w_cnt", b4.count_o, q.size());
      check("w_le4", (b4.count_o <= 4), 1);
      check("w_rdy", b4.inst_ready_o, (q.size() < 4));
      waddr   = 32'h100 + 32'(4 * pushed);
      do_push = (pushed < 10) && (q.size() < 4);
      do_pop  = (q.size() != 0) && pat[cyc % 16];
      b4.inst_valid_i = (pushed < 10);
      b4.inst_addr_i  = waddr;
      b4.inst_i       = 32'hB000_0000 | waddr;
      b4.id_ready_i   = pat[cyc % 16];
      if (do_pop) begin
        check("w_addr", b4.inst_addr_o, q[0]);
        check("w_inst", b4.inst_o, 32'hB000_0000 | q[0]);
      end
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(waddr);
        pushed++;
      end
      cyc++;
    end
    check("w_done", (cyc < 200), 1);
    check("w_pushed", pushed, 10);
    b4.inst_valid_i = 1'b0;
    b4.id_ready_i   = 1'b0;
    tick();
    check("w_empty", b4.inst_valid_o, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised instruction buffer between the fetch stage and the decode stage, replacing the single-entry IF/ID pipeline register. It holds up to DEPTH fetched instruction/address pairs, decouples fetch from decode stalls with a valid/ready handshake on both sides, and discards all buffered entries on a jump from EX. When empty it presents the NOP instruction with address zero, so decode always sees a legal instruction.

## Interface

- INST_W, 32, instruction width in bits
- ADDR_W, 32, instruction address width in bits
- DEPTH, 2, number of entries; power of two, ≥ 2
- NOP_INST, 32'h00000001, instruction presented when empty, after flush and after reset
- CNT_W, $clog2(DEPTH+1), width of the occupancy count

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-low (rst == 0 resets on the next rising edge of clk)
- inst_i  input  INST_W  fetched instruction
- inst_addr_i  input  ADDR_W  address of inst_i
- inst_valid_i  input  1  fetch presents a valid pair
- inst_ready_o  output  1  buffer accepts a pair this cycle
- jump_flag_ex_i  input  1  EX redirect; flush all entries
- inst_o  output  INST_W  head instruction to decode
- inst_addr_o  output  ADDR_W  head address to decode
- inst_valid_o  output  1  head entry valid
- id_ready_i  input  1  decode consumes head this cycle
- count_o  output  CNT_W  current occupancy, 0..DEPTH

## Operation

- Storage: circular buffer of DEPTH entries, write pointer, read pointer (log2(DEPTH) bits, wrap naturally), count register.
- Push: inst_valid_i & inst_ready_o & !jump_flag_ex_i → write entry at wptr, wptr+1.
- Pop: inst_valid_o & id_ready_i & !jump_flag_ex_i → rptr+1.
- Count: +1 on push only, −1 on pop only, unchanged on push and pop together.
- inst_ready_o = (count < DEPTH); simultaneous pop does not raise ready when full (no same-cycle pass-through of a slot).
- inst_valid_o = (count != 0).
- inst_o/inst_addr_o = entry[rptr] when count != 0; NOP_INST / 0 when count == 0.
- Flush (jump_flag_ex_i == 1): next cycle count=0, wptr=rptr=0; push and pop in the flush cycle are ignored; stored entries need not be cleared.
- Priority: reset > flush > push/pop.
- Values of inst_i/inst_addr_i when inst_valid_i == 0 are don't-care and never stored.

## Timing

- Reset values (cycle after rst sampled low): count_o=0, inst_valid_o=0, inst_ready_o=1, inst_o=NOP_INST, inst_addr_o=0, pointers 0.
- Latency: pair pushed at edge N appears on inst_o/inst_addr_o with inst_valid_o=1 in the cycle after edge N; no combinational input-to-output path.
- inst_ready_o, inst_valid_o, count_o depend only on registered count; inst_o/inst_addr_o are a mux of registered storage by rptr.
- Empty with push: no pop possible that cycle (inst_valid_o=0); entry visible next cycle.
- Full (count==DEPTH): inst_ready_o=0; a pop that cycle yields count=DEPTH−1 and inst_ready_o=1 next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with order preserved.
- Flush with count==DEPTH and inst_valid_i=1: incoming pair dropped; next cycle empty, ready=1.
- Reset mid-stream: identical to reset values regardless of count or flush.

## Test plan

- Reset: hold rst=0 two cycles with inst_valid_i=1, inst_i=32'hdeadbeef → after release count_o=0, inst_valid_o=0, inst_o=32'h00000001, inst_addr_o=0, inst_ready_o=1.
- Streaming: id_ready_i=1, push addrs 0x0,0x4,0x8 back-to-back → inst_addr_o shows 0x0,0x4,0x8 one cycle after each push, count_o stays 1.
- Fill/stall (DEPTH=2): id_ready_i=0, push 0x10,0x14,0x18 → third push refused (inst_ready_o=0, count_o=2); release id_ready_i → 0x10 then 0x14 output, 0x18 accepted only once ready returns.
- Flush: count_o=2, assert jump_flag_ex_i with push of 0x20 and id_ready_i=1 → next cycle count_o=0, inst_o=NOP_INST, inst_addr_o=0; 0x20 never appears.
- Wrap (DEPTH=4): 10 pushes with random id_ready_i stalls → output address sequence equals input sequence, count_o never exceeds 4.
- Simultaneous push+pop at count=1 → count_o stays 1, next head is the previously second-oldest pair.
